aligner_apb_regs: RTL

APB slave register file for the data aligner, sitting directly behind the APB bus and in front of the aligner datapath. It completes APB transfers with a fixed, parameterised number of wait states. It holds the aligner configuration (CTRL), interrupt enables (IRQEN) and sticky interrupt flags (IRQ), and maintains a saturating drop counter. Register writes are decoded into configuration outputs and a one-cycle clear pulse.

---
 rtl/aligner_apb_regs.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aligner_apb_regs.sv
// aligner_apb_regs -- APB slave register file for the data aligner.
//   APB side : pclk, preset_n, paddr, pwrite, psel, penable, pwdata -> pready, prdata, pslverr
//   Config   : ctrl_size, ctrl_offset, ctrl_clr (one-cycle clear pulse)
//   Status   : drop_pulse, rx_lvl, tx_lvl, FIFO event inputs -> irq
// Map: 0x00 CTRL, 0xF0 STATUS (RO), 0xF4 IRQEN, 0xF8 IRQ (W1C).
module aligner_apb_regs #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned LVL_W       = 4
) (
  input  logic             pclk,
  input  logic             preset_n,
  input  logic [15:0]      paddr,
  input  logic             pwrite,
  input  logic             psel,
  input  logic             penable,
  input  logic [31:0]      pwdata,
  output logic             pready,
  output logic [31:0]      prdata,
  output logic             pslverr,
  output logic [2:0]       ctrl_size,
  output logic [1:0]       ctrl_offset,
  output logic             ctrl_clr,
  input  logic             drop_pulse,
  input  logic [LVL_W-1:0] rx_lvl,
  input  logic [LVL_W-1:0] tx_lvl,
  input  logic             rx_empty_evt,
  input  logic             rx_full_evt,
  input  logic             tx_empty_evt,
  input  logic             tx_full_evt,
  output logic             irq
);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e      state_q, state_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  offset_q, offset_d;
  logic        clr_q, clr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  irqen_q, irqen_d;
  logic [4:0]  flags_q, flags_d;
  logic        irq_q, irq_d;

  logic        sel_ctrl, sel_status, sel_irqen, sel_irq;
  logic        err, commit;
  logic [31:0] rdata;
  logic [2:0]  wsize;
  logic [1:0]  woff;
  logic        max_evt;
  logic [4:0]  w1c;
  logic        unused_pwdata_bits;

  assign unused_pwdata_bits = ^{pwdata[31:17], pwdata[15:10], pwdata[7:5]};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          wcnt_d  = 2'(WAIT_STATES);
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (wcnt_q != 2'd0) wcnt_d = wcnt_q - 2'd1;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pready = (state_q == ACCESS) && (wcnt_q == 2'd0) && psel && penable;

  assign wsize = pwdata[2:0];
  assign woff  = pwdata[9:8];

  always_comb begin
    sel_ctrl   = (paddr == 16'h0000);
    sel_status = (paddr == 16'h00F0);
    sel_irqen  = (paddr == 16'h00F4);
    sel_irq    = (paddr == 16'h00F8);
    rdata      = '0;
    err        = 1'b0;
    if (sel_ctrl) begin
      rdata[2:0] = size_q;
      rdata[9:8] = offset_q;
      if (pwrite && (!(wsize == 3'd1 || wsize == 3'd2 || wsize == 3'd4) ||
                     (({2'b00, woff} + {1'b0, wsize}) > 4'd4)))
        err = 1'b1;
    end else if (sel_status) begin
      rdata[7:0]        = cnt_q;
      rdata[8 +: LVL_W]  = rx_lvl;
      rdata[16 +: LVL_W] = tx_lvl;
      err = pwrite;
    end else if (sel_irqen) begin
      rdata[4:0] = irqen_q;
    end else if (sel_irq) begin
      rdata[4:0] = flags_q;
    end else begin
      err = 1'b1;
    end
  end

  assign pslverr = pready && err;
  assign prdata  = (pready && !err) ? rdata : '0;
  assign commit  = pready && pwrite && !err;

  always_comb begin
    size_d   = size_q;
    offset_d = offset_q;
    irqen_d  = irqen_q;
    cnt_d    = cnt_q;
    clr_d    = commit && sel_ctrl && pwdata[16];
    if (commit && sel_ctrl) begin
      size_d   = wsize;
      offset_d = woff;
    end
    if (commit && sel_irqen) irqen_d = pwdata[4:0];
    // the pending clear pulse beats a drop in the same cycle
    if (clr_q)                             cnt_d = '0;
    else if (drop_pulse && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    max_evt = drop_pulse && !clr_q && (cnt_q == 8'hFE);
    w1c     = (commit && sel_irq) ? pwdata[4:0] : '0;
    // set events are OR-ed after the clear so a coincident event wins
    flags_d = (flags_q & ~w1c) |
              {max_evt, tx_full_evt, tx_empty_evt, rx_full_evt, rx_empty_evt};
    irq_d   = |(flags_q & irqen_q);
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      size_q   <= 3'd1;
      offset_q <= '0;
      clr_q    <= 1'b0;
      cnt_q    <= '0;
      irqen_q  <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      size_q   <= size_d;
      offset_q <= offset_d;
      clr_q    <= clr_d;
      cnt_q    <= cnt_d;
      irqen_q  <= irqen_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
    end
  end

  assign ctrl_size   = size_q;
  assign ctrl_offset = offset_q;
  assign ctrl_clr    = clr_q;
  assign irq         = irq_q;

endmodule
